uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small transmit FIFO.
// Bytes enter through a valid/ready handshake and are sent LSB first.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          uartTxPin,
    output logic                          busy,
    output logic                          fin,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [1:0]                    dbg_state
);

    // Handshake: a byte is taken on a rising edge where valid && ready;
    // ready depends only on registered occupancy, never on valid or data.

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FIN_CNT  = CW'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            push;
    logic            pop;
    logic            bit_done;

    assign ready     = (level != (AW+1)'(FIFO_DEPTH));
    assign busy      = (state != IDLE) || (level != '0);
    assign dbg_state = state;
    assign push      = valid && ready;
    assign bit_done  = (bit_cnt == LAST_CNT);
    // The FIFO head is consumed either from idle or at the last stop-bit cycle.
    assign pop       = (level != '0) &&
                       ((state == IDLE) || ((state == STOP) && bit_done));

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            uartTxPin <= 1'b1;
            fin       <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            fin <= 1'b0;
            case (state)
                IDLE: begin
                    uartTxPin <= 1'b1;
                    bit_cnt   <= '0;
                    if (pop) begin
                        shreg     <= mem[rd_ptr];
                        uartTxPin <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                        uartTxPin <= shreg[0];
                        state     <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uartTxPin <= 1'b1;
                            state     <= STOP;
                        end else begin
                            // shreg[0] is the bit currently on the line.
                            bit_idx   <= bit_idx + 1'b1;
                            shreg     <= shreg >> 1;
                            uartTxPin <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    fin <= (bit_cnt == FIN_CNT);
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shreg     <= mem[rd_ptr];
                            uartTxPin <= 1'b0;
                            state     <= START;
                        end else begin
                            uartTxPin <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    uartTxPin <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: cycle-exact frame checks plus a line decoder
// feeding a scoreboard for the FIFO ordering scenarios.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       uartTxPin;
    logic       busy;
    logic       fin;
    logic [2:0] level;
    logic [1:0] dbg_state;

    logic [7:0] data_d;
    logic       valid_d;
    logic       ready_d;
    logic       pin_d;
    logic       busy_d;
    logic       fin_d;
    logic [2:0] level_d;
    logic [1:0] dbg_state_d;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       mon_en;
    logic [7:0] mon_b;

    always #5 clock = ~clock;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .data(data), .valid(valid), .ready(ready),
        .uartTxPin(uartTxPin), .busy(busy), .fin(fin), .level(level),
        .dbg_state(dbg_state)
    );

    uart_tx dut_d (
        .clock(clock), .reset(reset), .data(data_d), .valid(valid_d), .ready(ready_d),
        .uartTxPin(pin_d), .busy(busy_d), .fin(fin_d), .level(level_d),
        .dbg_state(dbg_state_d)
    );

    // Expected line level at frame cycle k (1..10*CPB) for byte b.
    function automatic logic exp_pin(input logic [7:0] b, input int k);
        int bi;
        bi = (k - 1) / CPB;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        return b[bi-1];
    endfunction

    // Line decoder: samples each bit in its middle and queues the byte.
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en && !reset && uartTxPin === 1'b0) begin
                repeat (CPB/2) @(negedge clock);
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clock);
                    mon_b[j] = uartTxPin;
                end
                repeat (CPB) @(negedge clock);
                rx_q.push_back(mon_b);
                repeat (CPB/2 - 1) @(negedge clock);
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1; valid = 1'b1; data = 8'hAA; valid_d = 1'b1; data_d = 8'hAA;
        repeat (3) @(negedge clock);
        n_assert++; if (uartTxPin !== 1'b1) begin n_fail++; $display("FAIL reset_pin: got %b expected 1", uartTxPin); end
        n_assert++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_assert++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_assert++; if (fin !== 1'b0) begin n_fail++; $display("FAIL reset_fin: got %b expected 0", fin); end
        n_assert++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        n_assert++; if (level_d !== 3'd0 || pin_d !== 1'b1) begin n_fail++; $display("FAIL reset_dflt: level %0d pin %b expected 0/1", level_d, pin_d); end
        valid = 1'b0; valid_d = 1'b0; reset = 1'b0;
        @(negedge clock);
        n_assert++; if (level !== 3'd0 || uartTxPin !== 1'b1) begin n_fail++; $display("FAIL reset_ignore_hs: level %0d pin %b expected 0/1", level, uartTxPin); end
    endtask

    task automatic test_single;
        data = 8'h55; valid = 1'b1;
        @(negedge clock);
        valid = 1'b0; data = 8'hFF;
        n_assert++; if (uartTxPin !== 1'b1 || level !== 3'd1) begin n_fail++; $display("FAIL single_accept: pin %b level %0d expected 1/1", uartTxPin, level); end
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_queued: got %b expected 1", busy); end
        for (int k = 1; k <= 10*CPB; k++) begin
            @(negedge clock);
            n_assert++;
            if (uartTxPin !== exp_pin(8'h55, k) || fin !== (k == 10*CPB)) begin
                n_fail++;
                $display("FAIL single_frame k=%0d: pin %b fin %b expected %b/%b", k, uartTxPin, fin, exp_pin(8'h55, k), (k == 10*CPB));
            end
        end
        @(negedge clock);
        n_assert++; if (busy !== 1'b0 || fin !== 1'b0 || uartTxPin !== 1'b1) begin n_fail++; $display("FAIL single_end: busy %b fin %b pin %b expected 0/0/1", busy, fin, uartTxPin); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b;
        int         kk;
        data = 8'hA3; valid = 1'b1;
        @(negedge clock);
        data = 8'h0F;
        for (int k = 1; k <= 20*CPB; k++) begin
            @(negedge clock);
            if (k == 1) valid = 1'b0;
            b  = (k <= 10*CPB) ? 8'hA3 : 8'h0F;
            kk = (k <= 10*CPB) ? k : k - 10*CPB;
            n_assert++;
            if (uartTxPin !== exp_pin(b, kk) || fin !== (kk == 10*CPB)) begin
                n_fail++;
                $display("FAIL b2b_frame k=%0d: pin %b fin %b expected %b/%b", k, uartTxPin, fin, exp_pin(b, kk), (kk == 10*CPB));
            end
        end
        @(negedge clock);
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_stream;
        logic [7:0] bytes [6];
        int         idx;
        int         acc_at_drop;
        logic       will_acc;
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(bytes[i]);
        idx = 0; acc_at_drop = -1;
        data = bytes[0]; valid = 1'b1;
        for (int cyc = 0; cyc < 400 && idx < 6; cyc++) begin
            if (!ready && acc_at_drop < 0) begin
                acc_at_drop = idx;
                n_assert++; if (level !== 3'd4) begin n_fail++; $display("FAIL stream_full_level: got %0d expected 4", level); end
            end
            will_acc = ready;
            @(negedge clock);
            if (will_acc) begin
                idx++;
                if (idx < 6) data = bytes[idx];
                else valid = 1'b0;
            end
        end
        valid = 1'b0;
        n_assert++; if (acc_at_drop !== 5) begin n_fail++; $display("FAIL stream_ready_drop: after %0d accepts expected 5", acc_at_drop); end
        n_assert++; if (idx !== 6) begin n_fail++; $display("FAIL stream_accepts: got %0d expected 6", idx); end
        for (int t = 0; t < 2000 && busy; t++) @(negedge clock);
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_drain_timeout: busy %b expected 0", busy); end
        repeat (4) @(negedge clock);
        n_assert++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stream_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_assert++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_byte%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
        end
    endtask

    task automatic test_full_drop;
        logic [7:0] bytes [5];
        int         idx;
        logic       will_acc;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(bytes[i]);
        idx = 0;
        data = bytes[0]; valid = 1'b1;
        for (int cyc = 0; cyc < 50 && idx < 5; cyc++) begin
            will_acc = ready;
            @(negedge clock);
            if (will_acc) begin
                idx++;
                if (idx < 5) data = bytes[idx];
            end
        end
        n_assert++; if (level !== 3'd4 || ready !== 1'b0) begin n_fail++; $display("FAIL drop_full: level %0d ready %b expected 4/0", level, ready); end
        data = 8'h99; valid = 1'b1;
        @(negedge clock);
        valid = 1'b0;
        n_assert++; if (level !== 3'd4) begin n_fail++; $display("FAIL drop_level: got %0d expected 4", level); end
        for (int t = 0; t < 2000 && busy; t++) @(negedge clock);
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_drain_timeout: busy %b expected 0", busy); end
        repeat (4) @(negedge clock);
        n_assert++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL drop_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_assert++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL drop_byte%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        logic bad;
        mon_en = 1'b0;
        data = 8'hFF; valid = 1'b1;
        @(negedge clock);
        data = 8'h01;
        @(negedge clock);
        data = 8'h02;
        @(negedge clock);
        valid = 1'b0;
        n_assert++; if (level !== 3'd2) begin n_fail++; $display("FAIL rmid_queued: level %0d expected 2", level); end
        repeat (22) @(negedge clock);
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
        reset = 1'b1; valid = 1'b1; data = 8'h77;
        @(negedge clock);
        reset = 1'b0; valid = 1'b0;
        n_assert++; if (uartTxPin !== 1'b1 || level !== 3'd0 || ready !== 1'b1 || fin !== 1'b0) begin
            n_fail++; $display("FAIL rmid_after: pin %b level %0d ready %b fin %b expected 1/0/1/0", uartTxPin, level, ready, fin);
        end
        bad = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            if (uartTxPin !== 1'b1 || fin !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_assert++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rmid_silent: activity seen %b expected 0", bad); end
    endtask

    task automatic test_default_params;
        data_d = 8'h00; valid_d = 1'b1;
        @(negedge clock);
        valid_d = 1'b0;
        n_assert++; if (pin_d !== 1'b1 || level_d !== 3'd1) begin n_fail++; $display("FAIL dflt_accept: pin %b level %0d expected 1/1", pin_d, level_d); end
        for (int k = 1; k <= 1040; k++) begin
            @(negedge clock);
            n_assert++;
            if (pin_d !== (k > 936) || fin_d !== (k == 1040)) begin
                n_fail++; $display("FAIL dflt_frame k=%0d: pin %b fin %b expected %b/%b", k, pin_d, fin_d, (k > 936), (k == 1040));
            end
        end
        @(negedge clock);
        n_assert++; if (busy_d !== 1'b0 || fin_d !== 1'b0) begin n_fail++; $display("FAIL dflt_end: busy %b fin %b expected 0/0", busy_d, fin_d); end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; data = 8'h00; valid_d = 1'b0; data_d = 8'h00;
        mon_en = 1'b1;
        @(negedge clock);
        test_reset();
        repeat (3) @(negedge clock);
        test_single();
        repeat (3) @(negedge clock);
        test_back_to_back();
        repeat (3) @(negedge clock);
        test_full_stream();
        repeat (3) @(negedge clock);
        test_full_drop();
        repeat (3) @(negedge clock);
        test_reset_mid();
        repeat (3) @(negedge clock);
        test_default_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
